// File: rtl/gmii_rx_gen.sv
// Frames a byte stream as GMII receive traffic: preamble, SFD, payload, zero pad and CRC-32 FCS.
// GMII outputs lag the deciding state by one cycle; in_ready is high only in DATA, otherwise input stalls.
module gmii_rx_gen #(
  parameter int         IFG_BYTES      = 12,
  parameter int         PREAMBLE_BYTES = 7,
  parameter logic [7:0] SFD_BYTE       = 8'hD5,
  parameter bit         APPEND_FCS     = 1'b1,
  parameter bit         PAD_MIN        = 1'b1
) (
  input  logic        gmii_rxclk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_err,
  output logic        in_ready,
  output logic        gmii_rxctrl,
  output logic [7:0]  gmii_rxdata,
  output logic        gmii_rxerr,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {S_IFG, S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS} state_t;

  localparam logic [7:0]  LP_IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [7:0]  LP_PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [10:0] LP_MIN_LEN  = 11'd60;
  localparam logic [31:0] LP_CRC_INIT = 32'hFFFF_FFFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_tmr;
  logic [10:0] r_cnt;
  logic [31:0] r_crc;
  logic        r_ctrl;
  logic [7:0]  r_data;
  logic        r_err;
  logic [15:0] r_frame_cnt;

  logic        w_ctrl;
  logic [7:0]  w_data;
  logic        w_err;
  logic [7:0]  w_byte;
  logic        w_adv;
  logic        w_frame_done;
  logic [10:0] w_cnt_inc;
  logic [31:0] w_crc_upd;
  logic [31:0] w_fcs;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign w_cnt_inc = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
  assign w_crc_upd = crc_byte(r_crc, w_byte);
  assign w_fcs     = ~r_crc;

  assign in_ready    = (r_state == S_DATA);
  assign busy        = (r_state != S_IDLE);
  assign gmii_rxctrl = r_ctrl;
  assign gmii_rxdata = r_data;
  assign gmii_rxerr  = r_err;
  assign frame_cnt   = r_frame_cnt;

  always_comb begin
    w_state_nxt  = r_state;
    w_ctrl       = 1'b0;
    w_data       = 8'h00;
    w_err        = 1'b0;
    w_byte       = 8'h00;
    w_adv        = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      // A frame already waiting skips IDLE so back-to-back gaps are exactly IFG_BYTES long.
      S_IFG: begin
        if (r_tmr == LP_IFG_LAST) w_state_nxt = in_valid ? S_PRE : S_IDLE;
      end
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_PRE;
      end
      S_PRE: begin
        w_ctrl = 1'b1;
        w_data = 8'h55;
        if (r_tmr == LP_PRE_LAST) w_state_nxt = S_SFD;
      end
      S_SFD: begin
        w_ctrl      = 1'b1;
        w_data      = SFD_BYTE;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_ctrl = 1'b1;
        if (in_valid) begin
          w_data = in_data;
          w_err  = in_err;
          w_byte = in_data;
          w_adv  = 1'b1;
          if (in_last) begin
            if (PAD_MIN && (w_cnt_inc < LP_MIN_LEN)) begin
              w_state_nxt = S_PAD;
            end else if (APPEND_FCS) begin
              w_state_nxt = S_FCS;
            end else begin
              w_state_nxt  = S_IFG;
              w_frame_done = 1'b1;
            end
          end
        end else begin
          w_err = 1'b1;
        end
      end
      S_PAD: begin
        w_ctrl = 1'b1;
        w_adv  = 1'b1;
        if (w_cnt_inc >= LP_MIN_LEN) begin
          if (APPEND_FCS) begin
            w_state_nxt = S_FCS;
          end else begin
            w_state_nxt  = S_IFG;
            w_frame_done = 1'b1;
          end
        end
      end
      S_FCS: begin
        w_ctrl = 1'b1;
        w_data = 8'(w_fcs >> {r_tmr[1:0], 3'b000});
        if (r_tmr[1:0] == 2'd3) begin
          w_state_nxt  = S_IFG;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_nxt = S_IFG;
    endcase
  end

  always_ff @(posedge gmii_rxclk) begin
    if (rst) begin
      r_state     <= S_IFG;
      r_tmr       <= 8'd0;
      r_cnt       <= 11'd0;
      r_crc       <= LP_CRC_INIT;
      r_ctrl      <= 1'b0;
      r_data      <= 8'h00;
      r_err       <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= (w_state_nxt != r_state) ? 8'd0 : r_tmr + 8'd1;
      r_ctrl  <= w_ctrl;
      r_data  <= w_data;
      r_err   <= w_err;
      if (r_state == S_IFG) begin
        r_cnt <= 11'd0;
        r_crc <= LP_CRC_INIT;
      end else if (w_adv) begin
        r_cnt <= w_cnt_inc;
        r_crc <= w_crc_upd;
      end
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_gen.sv
// Directed bench for gmii_rx_gen: dut_a uses defaults (pad + FCS), dut_b has pad and FCS disabled.
module tb_gmii_rx_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_vld, a_last, a_err, a_rdy, a_ctrl, a_rerr, a_busy;
  logic [7:0]  a_dat, a_rdat;
  logic [15:0] a_fcnt;
  logic        b_vld, b_last, b_err, b_rdy, b_ctrl, b_rerr, b_busy;
  logic [7:0]  b_dat, b_rdat;
  logic [15:0] b_fcnt;

  gmii_rx_gen dut_a (
    .gmii_rxclk(clk), .rst(rst),
    .in_valid(a_vld), .in_data(a_dat), .in_last(a_last), .in_err(a_err), .in_ready(a_rdy),
    .gmii_rxctrl(a_ctrl), .gmii_rxdata(a_rdat), .gmii_rxerr(a_rerr),
    .busy(a_busy), .frame_cnt(a_fcnt)
  );

  gmii_rx_gen #(.APPEND_FCS(1'b0), .PAD_MIN(1'b0)) dut_b (
    .gmii_rxclk(clk), .rst(rst),
    .in_valid(b_vld), .in_data(b_dat), .in_last(b_last), .in_err(b_err), .in_ready(b_rdy),
    .gmii_rxctrl(b_ctrl), .gmii_rxdata(b_rdat), .gmii_rxerr(b_rerr),
    .busy(b_busy), .frame_cnt(b_fcnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line monitors: every ctrl=1 cycle logged as {err,data}; run lengths and idle gaps recorded.
  logic [8:0] log_a[$], log_b[$], exp_q[$];
  int len_a[$], len_b[$], gap_a[$];

  initial begin
    int run_a, idle_a, run_b;
    run_a = 0; idle_a = 0; run_b = 0;
    forever begin
      @(negedge clk);
      if (a_ctrl === 1'b1) begin
        log_a.push_back({a_rerr, a_rdat});
        if (run_a == 0) gap_a.push_back(idle_a);
        run_a++;
        idle_a = 0;
      end else begin
        if (run_a != 0) len_a.push_back(run_a);
        run_a = 0;
        idle_a++;
      end
      if (b_ctrl === 1'b1) begin
        log_b.push_back({b_rerr, b_rdat});
        run_b++;
      end else begin
        if (run_b != 0) len_b.push_back(run_b);
        run_b = 0;
      end
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  logic [31:0] crc_m;

  task automatic exp_start();
    exp_q.delete();
    crc_m = 32'hFFFF_FFFF;
    repeat (7) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic e);
    exp_q.push_back({e, d});
    crc_m = crc_upd(crc_m, d);
  endtask

  task automatic exp_fcs();
    logic [31:0] f;
    f = ~crc_m;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, f[8*i +: 8]});
  endtask

  task automatic push(input bit sel, input logic [7:0] d, input logic l, input logic e);
    int t;
    t = 0;
    @(negedge clk);
    if (sel) begin b_vld = 1'b1; b_dat = d; b_last = l; b_err = e; end
    else     begin a_vld = 1'b1; a_dat = d; a_last = l; a_err = e; end
    while (((sel ? b_rdy : a_rdy) !== 1'b1) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("push_timeout", t, 0);
  endtask

  task automatic release_in(input bit sel);
    @(negedge clk);
    if (sel) begin b_vld = 1'b0; b_last = 1'b0; b_err = 1'b0; end
    else     begin a_vld = 1'b0; a_last = 1'b0; a_err = 1'b0; end
  endtask

  task automatic wait_end(input bit sel, input string nm);
    int t;
    t = 0;
    while (((sel ? len_b.size() : len_a.size()) == 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk({nm, "_timeout"}, t, 0);
  endtask

  task automatic cmp_log(input bit sel, input string nm);
    int n;
    n = sel ? log_b.size() : log_a.size();
    chk({nm, "_nbytes"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk($sformatf("%s_byte%0d", nm, i), sel ? log_b[i] : log_a[i], exp_q[i]);
  endtask

  task automatic clear_logs();
    log_a.delete(); log_b.delete(); len_a.delete(); len_b.delete(); gap_a.delete();
  endtask

  initial begin
    int t, nerr;
    rst = 1'b1;
    a_vld = 0; a_dat = 0; a_last = 0; a_err = 0;
    b_vld = 0; b_dat = 0; b_last = 0; b_err = 0;
    repeat (3) @(negedge clk);

    chk("rst_ctrl", a_ctrl, 0);
    chk("rst_data", a_rdat, 0);
    chk("rst_err", a_rerr, 0);
    chk("rst_ready", a_rdy, 0);
    chk("rst_fcnt", a_fcnt, 0);
    chk("rst_busy", a_busy, 1);
    chk("rst_fcnt_b", b_fcnt, 0);
    rst = 1'b0;

    // 1-byte frame right after reset: idle gap, then pad to 60 and FCS.
    t = 0;
    fork
      push(1'b0, 8'hAB, 1'b1, 1'b0);
      while (a_ctrl !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    join
    chk("rst_gap_ge12", (t >= 12 && t < 100) ? 1 : 0, 1);
    release_in(1'b0);
    wait_end(1'b0, "pad");
    exp_start();
    exp_byte(8'hAB, 1'b0);
    repeat (59) exp_byte(8'h00, 1'b0);
    exp_fcs();
    cmp_log(1'b0, "pad");
    chk("pad_ctrl_len", len_a.size() > 0 ? len_a[0] : 0, 72);
    chk("pad_fcnt", a_fcnt, 1);
    clear_logs();

    // 64-byte incrementing frame on the no-pad, no-FCS instance.
    for (int i = 0; i < 64; i++) push(1'b1, 8'(i), (i == 63), 1'b0);
    release_in(1'b1);
    wait_end(1'b1, "basic");
    exp_start();
    for (int i = 0; i < 64; i++) exp_byte(8'(i), 1'b0);
    cmp_log(1'b1, "basic");
    chk("basic_ctrl_len", len_b.size() > 0 ? len_b[0] : 0, 72);
    chk("basic_fcnt", b_fcnt, 1);
    chk("basic_ready_after", b_rdy, 0);
    clear_logs();

    // Underrun of two cycles, then one errored byte; FCS covers only the real bytes.
    for (int i = 0; i < 4; i++) push(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    a_vld = 1'b0;
    @(negedge clk);
    push(1'b0, 8'h14, 1'b0, 1'b1);
    for (int i = 5; i < 8; i++) push(1'b0, 8'h10 + 8'(i), (i == 7), 1'b0);
    release_in(1'b0);
    wait_end(1'b0, "urun");
    exp_start();
    for (int i = 0; i < 4; i++) exp_byte(8'h10 + 8'(i), 1'b0);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h100);
    exp_byte(8'h14, 1'b1);
    for (int i = 5; i < 8; i++) exp_byte(8'h10 + 8'(i), 1'b0);
    repeat (52) exp_byte(8'h00, 1'b0);
    exp_fcs();
    cmp_log(1'b0, "urun");
    nerr = 0;
    foreach (log_a[i]) if (log_a[i][8]) nerr++;
    chk("urun_err_cycles", nerr, 3);
    chk("urun_ctrl_len", len_a.size() > 0 ? len_a[0] : 0, 74);
    chk("urun_fcnt", a_fcnt, 2);
    clear_logs();

    // Back-to-back frames with valid held high, then reset mid-payload of the second.
    for (int i = 0; i < 60; i++) push(1'b0, 8'(3 * i), (i == 59), 1'b0);
    for (int i = 0; i < 10; i++) push(1'b0, 8'hC0 + 8'(i), 1'b0, 1'b0);
    chk("b2b_len1", len_a.size() > 0 ? len_a[0] : 0, 72);
    chk("b2b_ngaps", gap_a.size(), 2);
    chk("b2b_gap", gap_a.size() > 1 ? gap_a[1] : 0, 12);
    chk("b2b_fcnt", a_fcnt, 3);
    chk("b2b_busy", a_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    a_vld = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", a_ctrl, 0);
    chk("midrst_err", a_rerr, 0);
    chk("midrst_ready", a_rdy, 0);
    chk("midrst_fcnt", a_fcnt, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_quiet", a_ctrl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
